// File: rtl/iq_symbol_mapper_tx.sv
// QPSK / 16-QAM transmit symbol mapper: preamble + payload, each symbol held SPS clocks.
// Optional payload scrambler (x^7+x^6+1 LFSR) enabled by defining SCRAMBLER_EN.
module iq_symbol_mapper_tx #(
  parameter int unsigned SPS      = 4,
  parameter int unsigned PRE_SYMS = 8,
  parameter logic [3:0]  LVL_Q_LO = 4'd4,
  parameter logic [3:0]  LVL_Q_HI = 4'd11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mod_sel,
  output logic [3:0] out_I,
  output logic [3:0] out_Q,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t     state;
  logic [7:0] buf_data;
  logic       buf_full;
  logic [7:0] shifter;
  logic       mod_r;
  logic [7:0] samp_cnt;
  logic [7:0] sym_cnt;

  logic       hs, last_samp, pre_end, byte_end, unload, buf_full_nxt;
  logic [7:0] load_byte;

  function automatic logic [3:0] gray_lvl(input logic [1:0] p);
    case (p)
      2'b00:   gray_lvl = 4'd1;
      2'b01:   gray_lvl = 4'd5;
      2'b11:   gray_lvl = 4'd10;
      default: gray_lvl = 4'd14;
    endcase
  endfunction

  // Returns {I, Q} for symbol idx of byte b.
  function automatic logic [7:0] sym_code(input logic [7:0] b, input logic [1:0] idx,
                                          input logic qam);
    logic [3:0] nib;
    logic [1:0] pair;
    nib  = idx[0] ? b[3:0] : b[7:4];
    case (idx)
      2'd0:    pair = b[7:6];
      2'd1:    pair = b[5:4];
      2'd2:    pair = b[3:2];
      default: pair = b[1:0];
    endcase
    if (qam)
      sym_code = {gray_lvl(nib[3:2]), gray_lvl(nib[1:0])};
    else
      sym_code = {(pair[1] ? LVL_Q_HI : LVL_Q_LO), (pair[0] ? LVL_Q_HI : LVL_Q_LO)};
  endfunction

`ifdef SCRAMBLER_EN
  logic [6:0] lfsr;
  logic [6:0] lfsr_nxt;

  // Whole byte is scrambled at load time; every loaded bit is transmitted, so the
  // per-bit LFSR sequence is unchanged.
  always_comb begin
    lfsr_nxt  = lfsr;
    load_byte = buf_data;
    for (int unsigned i = 0; i < 8; i++) begin
      load_byte[7-i] = buf_data[7-i] ^ lfsr_nxt[6];
      lfsr_nxt       = {lfsr_nxt[5:0], lfsr_nxt[6] ^ lfsr_nxt[5]};
    end
  end
`else
  always_comb load_byte = buf_data;
`endif

  always_comb begin
    hs           = in_valid & in_ready;
    last_samp    = (samp_cnt == 8'(SPS - 1));
    pre_end      = (state == PREAMBLE) && last_samp && (sym_cnt == 8'(PRE_SYMS - 1));
    byte_end     = (state == DATA) && last_samp && (sym_cnt == (mod_r ? 8'd1 : 8'd3));
    unload       = pre_end | (byte_end & buf_full);
    buf_full_nxt = hs | (buf_full & ~unload);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      buf_data  <= '0;
      buf_full  <= 1'b0;
      in_ready  <= 1'b1;
      shifter   <= '0;
      mod_r     <= 1'b0;
      samp_cnt  <= '0;
      sym_cnt   <= '0;
      out_I     <= 4'd8;
      out_Q     <= 4'd8;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SCRAMBLER_EN
      lfsr      <= '0;
`endif
    end else begin
      buf_full <= buf_full_nxt;
      in_ready <= ~buf_full_nxt;
      if (hs) buf_data <= in_data;

      case (state)
        IDLE: begin
          if (buf_full) begin
            state     <= PREAMBLE;
            mod_r     <= mod_sel;
            samp_cnt  <= '0;
            sym_cnt   <= '0;
            out_I     <= LVL_Q_HI;
            out_Q     <= LVL_Q_HI;
            out_valid <= 1'b1;
            busy      <= 1'b1;
`ifdef SCRAMBLER_EN
            lfsr      <= 7'h7F;
`endif
          end
        end

        PREAMBLE: begin
          if (pre_end) begin
            state            <= DATA;
            shifter          <= load_byte;
            samp_cnt         <= '0;
            sym_cnt          <= '0;
            {out_I, out_Q}   <= sym_code(load_byte, 2'd0, mod_r);
`ifdef SCRAMBLER_EN
            lfsr             <= lfsr_nxt;
`endif
          end else if (last_samp) begin
            samp_cnt <= '0;
            sym_cnt  <= sym_cnt + 8'd1;
            // Next symbol index is odd (LO) when the current one is even.
            out_I    <= sym_cnt[0] ? LVL_Q_HI : LVL_Q_LO;
            out_Q    <= sym_cnt[0] ? LVL_Q_HI : LVL_Q_LO;
          end else begin
            samp_cnt <= samp_cnt + 8'd1;
          end
        end

        DATA: begin
          if (byte_end) begin
            samp_cnt <= '0;
            sym_cnt  <= '0;
            if (buf_full) begin
              shifter        <= load_byte;
              {out_I, out_Q} <= sym_code(load_byte, 2'd0, mod_r);
`ifdef SCRAMBLER_EN
              lfsr           <= lfsr_nxt;
`endif
            end else begin
              state     <= IDLE;
              out_I     <= 4'd8;
              out_Q     <= 4'd8;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end else if (last_samp) begin
            samp_cnt       <= '0;
            sym_cnt        <= sym_cnt + 8'd1;
            {out_I, out_Q} <= sym_code(shifter, 2'(sym_cnt[1:0] + 2'd1), mod_r);
          end else begin
            samp_cnt <= samp_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/iq_symbol_mapper_tx.md
Name: iq_symbol_mapper_tx

Overview:
Transmit-side counterpart of the constellation-density receive path. Accepts payload bytes over a valid/ready handshake and prepends a fixed preamble to each frame. Maps payload bits to QPSK or 16-QAM symbols and emits each symbol as 4-bit unsigned I/Q codes held for SPS clocks. The output drives a DAC or loops directly back into the I/Q receive inputs for self-test.

Parameters:
SPS, 4, samples (clocks) each symbol is held; legal range 1..255
PRE_SYMS, 8, preamble length in symbols; legal range 1..255
LVL_Q_LO, 4, QPSK code for bit 0
LVL_Q_HI, 11, QPSK code for bit 1

Ports:
clk  input  1  system clock
rst  input  1  reset
in_data  input  8  payload byte, MSB transmitted first
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a byte
mod_sel  input  1  0=QPSK, 1=16-QAM; sampled at frame start
out_I  output  4  in-phase code, unsigned
out_Q  output  4  quadrature code, unsigned
out_valid  output  1  out_I/out_Q carry a frame sample
busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. All outputs are registered.
- Reset values: out_I=8, out_Q=8, out_valid=0, busy=0, in_ready=1. The byte buffer is emptied and all counters are zeroed.
- Byte buffer: one entry.
  - in_ready = !buf_full.
  - A handshake (in_valid & in_ready at an edge) writes the buffer.
  - Unloading the buffer into the shifter and a new handshake may occur on the same edge.
- States: IDLE, PREAMBLE, DATA.
- IDLE:
  - Outputs are 8/8 with out_valid=0.
  - When buf_full at an edge: latch mod_sel into mod_r, move to PREAMBLE, drive preamble symbol 0, set out_valid=1.
  - The first preamble sample is visible one clock after the edge that follows the accept.
- PREAMBLE:
  - PRE_SYMS symbols, each held SPS clocks.
  - Symbols alternate I=Q=LVL_Q_HI then I=Q=LVL_Q_LO, starting with HI. The preamble is always QPSK, whatever mod_sel is.
  - On the last sample, load the buffer byte into the shifter (buffer frees) and go to DATA.
- DATA:
  - QPSK uses 4 symbols per byte. Bits [7:6], [5:4], ... are consumed in that order. The upper bit of each pair drives I and the lower bit drives Q; bit 0 maps to LVL_Q_LO and bit 1 to LVL_Q_HI.
  - 16-QAM uses 2 symbols per byte, high nibble first. Nibble bits [3:2] drive I and bits [1:0] drive Q, Gray-mapped 00→1, 01→5, 11→10, 10→14.
  - On the last sample of a byte's last symbol:
    - if buf_full: load the next byte into the shifter, with no gap in output;
    - otherwise: go to IDLE; the next cycle has out_valid=0 and outputs 8/8.
- Counters:
  - The sample counter runs 0..SPS-1.
  - The symbol counter runs 0..PRE_SYMS-1 in PREAMBLE, and 0..3 (QPSK) or 0..1 (16-QAM) in DATA.
  - Both counters wrap to 0 on each symbol or byte boundary.
- mod_r holds the mod_sel value latched at frame start. mod_sel changes mid-frame are ignored until the next frame.
- Reset asserted mid-frame: outputs immediately (asynchronously) take their reset values, and any buffered byte is dropped.
- busy=1 in PREAMBLE and DATA.

Optional Feature:
SCRAMBLER_EN:
- Defined: each payload bit, in transmit order, is XORed with the output of a 7-bit LFSR (x^7+x^6+1, Fibonacci form).
  - The LFSR is seeded to 7'h7F on entry to PREAMBLE.
  - It advances once per payload bit.
  - The preamble is not scrambled.
- Undefined: bits pass unscrambled and no LFSR logic is instantiated.

Test Plan:
- Reset, then idle 10 cycles -> out_I=out_Q=8, out_valid=0, in_ready=1, busy=0 throughout.
- QPSK single byte 0xB4 (SPS=4, PRE_SYMS=8) -> 32 preamble cycles alternating (11,11)/(4,4) in 4-cycle groups. Then (11,4), (11,11), (4,11), (4,4) for 4 cycles each. Then out_valid=0 and busy=0.
- 16-QAM single byte 0xB4 -> 32 preamble cycles as above. Then (14,10) for 4 cycles and (5,1) for 4 cycles. Then idle.
- QPSK back-to-back 0xFF, 0x00, 0x5A with in_valid held high -> 32+48 contiguous out_valid cycles with no gap. in_ready deasserts while the buffer is full. The 0x5A symbols are (4,11) (4,11) (11,4) (11,4).
- Toggle mod_sel from 0 to 1 after the preamble starts -> the frame remains QPSK; the next frame starts 16-QAM.
- Assert rst during the 3rd data symbol with a second byte buffered -> outputs go to 8/8 and out_valid=0 that cycle. After release: in_ready=1, and no stale byte is transmitted.
